// File: rtl/alu_seq_muldiv.sv
// Execute-stage ALU: RV32I integer ops complete in one cycle, RV32M multiply/divide
// run one bit per cycle, with valid/ready handshakes on input and output.
module alu_seq_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_eq
);

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_AND    = 5'd2;
    localparam logic [4:0] OP_OR     = 5'd3;
    localparam logic [4:0] OP_SLL    = 5'd4;
    localparam logic [4:0] OP_SLT    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_XOR    = 5'd8;
    localparam logic [4:0] OP_SLTU   = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_r, state_n;
    logic [CNT_W-1:0]  cnt_r, cnt_n;
    logic [4:0]        op_r, op_n;
    logic [XLEN-1:0]   opnd_r, opnd_n;
    logic [2*XLEN-1:0] acc_r, acc_n;
    logic              neg_r, neg_n;
    logic              eq_r, eq_n;
    logic [XLEN-1:0]   result_r, result_n;
    logic              out_eq_r, out_eq_n;
    logic              in_ready_r, out_valid_r;

    logic [CNT_W-1:0]  shamt_s;
    logic [XLEN-1:0]   alu_s, mag_a_s, mag_b_s, fast_s, quo_s, rem_s, fix_s;
    logic              is_iter_s, is_div_s, is_rem_s, a_sgn_s, b_sgn_s;
    logic              b_zero_s, ovf_s, eq_in_s, div_ge_s;
    logic [XLEN:0]     mul_sum_s, div_shift_s, div_diff_s;
    logic [2*XLEN-1:0] mul_next_s, div_next_s, prod_fix_s;

    assign shamt_s   = in_b[CNT_W-1:0];
    assign is_iter_s = (in_op[4:3] == 2'b10);
    assign is_div_s  = (in_op[4:2] == 3'b101);
    assign is_rem_s  = is_div_s & in_op[1];
    assign a_sgn_s   = in_a[XLEN-1] & ((in_op == OP_MULH) | (in_op == OP_MULHSU) |
                                       (in_op == OP_DIV)  | (in_op == OP_REM));
    assign b_sgn_s   = in_b[XLEN-1] & ((in_op == OP_MULH) | (in_op == OP_DIV) | (in_op == OP_REM));
    assign mag_a_s   = a_sgn_s ? -in_a : in_a;
    assign mag_b_s   = b_sgn_s ? -in_b : in_b;
    assign eq_in_s   = (in_a == in_b);
    assign b_zero_s  = (in_b == {XLEN{1'b0}});
    assign ovf_s     = ((in_op == OP_DIV) | (in_op == OP_REM)) &
                       (in_a == {1'b1, {(XLEN-1){1'b0}}}) & (in_b == {XLEN{1'b1}});
    assign fast_s    = b_zero_s ? (is_rem_s ? in_a : {XLEN{1'b1}})
                                : (is_rem_s ? {XLEN{1'b0}} : in_a);

    // Multiply: acc holds {partial product, remaining multiplier bits}, shifted right per step.
    assign mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
    assign mul_next_s = {mul_sum_s, acc_r[XLEN-1:1]};

    // Divide: acc holds {remainder, dividend/quotient}; borrow bit of the trial subtract decides.
    assign div_shift_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
    assign div_diff_s  = div_shift_s - {1'b0, opnd_r};
    assign div_ge_s    = ~div_diff_s[XLEN];
    assign div_next_s  = {(div_ge_s ? div_diff_s[XLEN-1:0] : div_shift_s[XLEN-1:0]),
                          acc_r[XLEN-2:0], div_ge_s};

    assign prod_fix_s = neg_r ? -acc_r : acc_r;
    assign quo_s      = neg_r ? -acc_r[XLEN-1:0] : acc_r[XLEN-1:0];
    assign rem_s      = neg_r ? -acc_r[2*XLEN-1:XLEN] : acc_r[2*XLEN-1:XLEN];

    // Single-cycle integer result for the op presented at the input.
    always_comb begin
        alu_s = {XLEN{1'b0}};
        case (in_op)
            OP_ADD:  alu_s = in_a + in_b;
            OP_SUB:  alu_s = in_a - in_b;
            OP_AND:  alu_s = in_a & in_b;
            OP_OR:   alu_s = in_a | in_b;
            OP_SLL:  alu_s = in_a << shamt_s;
            OP_SLT:  alu_s = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            OP_SRL:  alu_s = in_a >> shamt_s;
            OP_SRA:  alu_s = $unsigned($signed(in_a) >>> shamt_s);
            OP_XOR:  alu_s = in_a ^ in_b;
            OP_SLTU: alu_s = {{(XLEN-1){1'b0}}, (in_a < in_b)};
            default: alu_s = {XLEN{1'b0}};
        endcase
    end

    // Final selection of the iterative result after sign correction.
    always_comb begin
        fix_s = {XLEN{1'b0}};
        case (op_r)
            OP_MUL:                        fix_s = prod_fix_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_s = prod_fix_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fix_s = quo_s;
            OP_REM, OP_REMU:               fix_s = rem_s;
            default:                       fix_s = {XLEN{1'b0}};
        endcase
    end

    // Next-state and datapath update; flush wins over everything but rst.
    always_comb begin
        state_n  = state_r;
        cnt_n    = cnt_r;
        op_n     = op_r;
        opnd_n   = opnd_r;
        acc_n    = acc_r;
        neg_n    = neg_r;
        eq_n     = eq_r;
        result_n = result_r;
        out_eq_n = out_eq_r;
        if (flush) begin
            state_n = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_n = in_op;
                        eq_n = eq_in_s;
                        if (!is_iter_s) begin
                            result_n = alu_s;
                            out_eq_n = eq_in_s;
                            state_n  = ST_DONE;
                        end else if (is_div_s && (b_zero_s || ovf_s)) begin
                            result_n = fast_s;
                            out_eq_n = eq_in_s;
                            state_n  = ST_DONE;
                        end else begin
                            opnd_n  = is_div_s ? mag_b_s : mag_a_s;
                            acc_n   = {{XLEN{1'b0}}, (is_div_s ? mag_a_s : mag_b_s)};
                            neg_n   = is_rem_s ? a_sgn_s : (a_sgn_s ^ b_sgn_s);
                            cnt_n   = {CNT_W{1'b0}};
                            state_n = ST_ITER;
                        end
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_ITER: begin
                    acc_n = op_r[2] ? div_next_s : mul_next_s;
                    cnt_n = cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(XLEN-1)) begin
                        state_n = ST_FIX;
                    end else begin
                        state_n = ST_ITER;
                    end
                end
                ST_FIX: begin
                    result_n = fix_s;
                    out_eq_n = eq_r;
                    state_n  = ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_DONE;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    // State, datapath and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            op_r        <= 5'd0;
            opnd_r      <= {XLEN{1'b0}};
            acc_r       <= {(2*XLEN){1'b0}};
            neg_r       <= 1'b0;
            eq_r        <= 1'b0;
            result_r    <= {XLEN{1'b0}};
            out_eq_r    <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            cnt_r       <= cnt_n;
            op_r        <= op_n;
            opnd_r      <= opnd_n;
            acc_r       <= acc_n;
            neg_r       <= neg_n;
            eq_r        <= eq_n;
            result_r    <= result_n;
            out_eq_r    <= out_eq_n;
            in_ready_r  <= (state_n == ST_IDLE);
            out_valid_r <= (state_n == ST_DONE);
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_result = result_r;
    assign out_eq     = out_eq_r;

endmodule
